// File: rtl/demux5_8b_stream.sv
// ============================================================================
// demux5_8b_stream : routes a tagged byte stream to five registered channels.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module demux5_8b_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [2:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic [2:0]       c_num_ch  = 3'd5;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [DATA_W-1:0] r_hold_data [5];
  logic [4:0]        r_hold_valid;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_drop;

  assign w_is_drop = (in_sel >= c_num_ch);

  // in_valid is deliberately absent so upstream can wait on in_ready safely.
  always_comb begin
    w_in_ready = 1'b1;
    if (!w_is_drop) begin
      w_in_ready = !r_hold_valid[in_sel] || out_ready[in_sel];
    end
  end

  assign w_accept = in_valid && w_in_ready;

  generate
    for (genvar k = 0; k < 5; k++) begin : g_ch
      logic w_load;
      assign w_load = w_accept && (in_sel == 3'(k));

      // A load in the same cycle as a drain wins, so back-to-back beats never bubble.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold_valid[k] <= 1'b0;
          r_hold_data[k]  <= '0;
        end else if (w_load) begin
          r_hold_valid[k] <= 1'b1;
          r_hold_data[k]  <= in_data;
        end else if (r_hold_valid[k] && out_ready[k]) begin
          r_hold_valid[k] <= 1'b0;
        end
      end

      assign out_data[k*DATA_W +: DATA_W] = r_hold_data[k];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_accept && w_is_drop && (r_drop_cnt != c_cnt_max)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_hold_valid;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_demux5_8b_stream.sv
// ============================================================================
// tb_demux5_8b_stream : scoreboard bench with directed and random traffic.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux5_8b_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] out_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [7:0]  drop_cnt;
  logic        in_ready2;
  logic [39:0] out_data2;
  logic [4:0]  out_valid2;
  logic [1:0]  drop_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: one queue of pending bytes per channel, plus a drop total
  logic [7:0] q [5][$];
  int         exp_drops = 0;

  demux5_8b_stream #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  demux5_8b_stream #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every falling edge, compare channel state against the model and retire transfers
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          chk($sformatf("out_data[%0d]", k), 64'(out_data[k*8 +: 8]), 64'(q[k][0]));
          if (out_ready[k]) void'(q[k].pop_front());
        end
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops > 255 ? 255 : exp_drops));
      chk("drop_cnt_sat", 64'(drop_cnt2), 64'(exp_drops > 3 ? 3 : exp_drops));
    end
  end

  // one cycle of stimulus; the expected outcome is pushed after the monitor has run
  task automatic beat(input logic v, input logic [2:0] s, input logic [7:0] d,
                      input logic [4:0] r);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    #1;
    if (s >= 3'd5) exp_rdy = 1'b1;
    else           exp_rdy = (q[s].size() == 0) || r[s];
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (v && exp_rdy) begin
      if (s < 3'd5) q[s].push_back(d);
      else          exp_drops++;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_drop_cnt"},  64'(drop_cnt),  64'd0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    #3;
    reset_checks("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // basic routing
    for (int k = 0; k < 5; k++) beat(1'b1, 3'(k), 8'hA0 + 8'(k), 5'b11111);
    beat(1'b0, 3'd0, 8'h00, 5'b11111);

    // drops, then two more to push the narrow counter into saturation
    beat(1'b1, 3'd5, 8'hD5, 5'b11111);
    beat(1'b1, 3'd6, 8'hD6, 5'b11111);
    beat(1'b1, 3'd7, 8'hD7, 5'b11111);
    beat(1'b1, 3'd5, 8'hD8, 5'b11111);
    beat(1'b1, 3'd7, 8'hD9, 5'b11111);

    // back-pressure on channel 2, then simultaneous drain and reload
    beat(1'b1, 3'd2, 8'h11, 5'b11011);
    beat(1'b1, 3'd2, 8'h22, 5'b11011);
    beat(1'b1, 3'd2, 8'h22, 5'b11011);
    beat(1'b1, 3'd2, 8'h22, 5'b11111);
    beat(1'b0, 3'd0, 8'h00, 5'b11011);

    // independence: channel 0 stalled and full while channel 4 flows
    beat(1'b1, 3'd0, 8'h33, 5'b11110);
    beat(1'b1, 3'd0, 8'h44, 5'b11110);
    beat(1'b1, 3'd4, 8'h55, 5'b11110);
    beat(1'b0, 3'd0, 8'h00, 5'b11110);
    beat(1'b0, 3'd0, 8'h00, 5'b11111);

    // reset mid-stream with channels 1 and 3 holding data
    beat(1'b1, 3'd1, 8'h61, 5'b10101);
    beat(1'b1, 3'd3, 8'h63, 5'b10101);
    beat(1'b0, 3'd0, 8'h00, 5'b10101);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    for (int k = 0; k < 5; k++) q[k].delete();
    exp_drops = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // randomized traffic with random consumer back-pressure
    for (int i = 0; i < 3000; i++) begin
      beat(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 5'($urandom));
    end
    for (int i = 0; i < 4; i++) beat(1'b0, 3'd0, 8'h00, 5'b11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux5_8b_stream.md
# demux5_8b_stream

Five-way stream demultiplexer: the distribution side of the team's 5:1 byte selector. A single 8-bit input stream carries a 3-bit destination tag and is routed to one of five registered output channels. Each channel has its own valid/ready handshake and a one-entry holding register. Destination tags 5–7 are consumed, discarded and counted. The block sits between a tagged byte producer and five independent byte consumers.

## Interface
Parameters:
- DATA_W, 8, width of each data byte/word.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_data  in  DATA_W  input payload.
- in_sel  in  3  destination tag: 0–4 select a channel, 5–7 are invalid.
- in_valid  in  1  input payload and tag are valid.
- in_ready  out  1  block accepts the input this cycle.
- out_data  out  5*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  5  per-channel valid.
- out_ready  in  5  per-channel consumer ready.
- drop_cnt  out  CNT_W  number of accepted beats with in_sel ≥ 5; saturates at all-ones.

## Operation
- Per channel k:
  - hold_valid[k] drives out_valid[k].
  - hold_data[k] drives out_data slice k.
- Handshake transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer on k: out_valid[k] && out_ready[k].
- in_ready is combinational:
  - If in_sel ≥ 5: 1.
  - Otherwise: !out_valid[in_sel] || out_ready[in_sel].
  - No path from in_valid to in_ready.
- Accept with in_sel = k (0–4):
  - hold_data[k] ← in_data.
  - hold_valid[k] ← 1.
- Accept with in_sel = 5–7:
  - Data discarded; no channel state changes.
  - drop_cnt increments by 1 unless it is already all-ones. It saturates and never wraps.
- Channel k with an output transfer and no load to k that cycle: hold_valid[k] ← 0. hold_data[k] keeps its old value.
- Simultaneous output transfer and load on the same k: hold_valid[k] stays 1 and hold_data[k] takes the new in_data. No bubble.
- Blocking:
  - A full channel with out_ready low stalls only beats tagged for it (head-of-line blocking).
  - Other channels keep draining independently.
- While out_valid[k] = 1 and no transfer occurs, out_data slice k is stable.
- Never more than one channel loads per cycle.
- Reset (asserted at any time, including mid-transfer):
  - out_valid = 0, all out_data slices = 0, drop_cnt = 0.
  - Held beats are lost.
  - in_ready is still evaluated from the cleared state: it is 1 during reset for any in_sel. Upstream must not present beats during reset.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput:
  - One beat per cycle overall.
  - Sustained one beat per cycle into a single channel when its out_ready stays high.
- drop_cnt updates the cycle after the dropped beat is accepted.
- Reset is asynchronous assert. Deassertion is assumed synchronised externally; the first accept can occur on the first edge after rst_n rises.
- Combinational paths:
  - in_sel → in_ready.
  - out_ready → in_ready.
  - All outputs other than in_ready are registered.

## Test plan
- Reset mid-stream: rst_n low while channels 1 and 3 hold data -> out_valid=5'b00000, out_data=0, drop_cnt=0 immediately, without waiting for a clock edge.
- Basic routing: send 8'hA0..8'hA4 with in_sel 0..4 on consecutive cycles, all out_ready=1 -> each out_valid[k] pulses one cycle, one edge after its accept, with data A0+k; in_ready stays 1 throughout.
- Back-pressure: out_ready[2]=0, send 8'h11 then 8'h22 to ch2 -> first accepted, in_ready=0 on the second. Raise out_ready[2] -> 8'h11 transfers and 8'h22 is accepted in the same cycle; out_valid[2] stays 1 with 8'h22.
- Independence: ch0 stalled and full; send 8'h55 to ch4 -> accepted, appears on ch4 next cycle; ch0 data unchanged.
- Drops: send 3 beats with in_sel=5, 6, 7 -> all accepted, no out_valid change, drop_cnt=3. With CNT_W=2, send 5 drops -> drop_cnt saturates at 3.
